// File: rtl/mod_solinas_pipe.sv
// Two-stage modular reduce/add/sub unit for the Solinas prime
// p = 2^(3W) - 2^W - 1 (W=64 gives P-192).
// Stage 1 folds the operand into an unreduced sum S < 4p.
// Stage 2 removes up to 3p by picking the smallest non-negative candidate.
// Both ends use valid/ready handshakes, and an opaque tag travels with each op.

module mod_solinas_pipe #(
   parameter int W     = 64,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_op,
   input  logic [6*W-1:0]     in_a,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [3*W-1:0]     out_data,
   output logic [TAG_W-1:0]   out_tag,
   output logic               out_err
);

   localparam int F  = 3 * W;
   localparam int SW = F + 2;
   localparam int DW = F + 3;

   // p = all-ones top word, FF..FE middle word, all-ones low word
   localparam logic [F-1:0]  P_F = {{W{1'b1}}, {(W-1){1'b1}}, 1'b0, {W{1'b1}}};
   localparam logic [SW-1:0] P_S = {2'b00, P_F};
   localparam logic [DW-1:0] P1  = {3'b000, P_F};
   localparam logic [DW-1:0] P2  = {2'b00, P_F, 1'b0};
   localparam logic [DW-1:0] P3  = P1 + P2;

   typedef enum logic [1:0] {
      OP_REDUCE = 2'd0,
      OP_ADD    = 2'd1,
      OP_SUB    = 2'd2,
      OP_RSVD   = 2'd3
   } op_e;

   op_e            op;
   logic [W-1:0]   a0, a1, a2, a3, a4, a5;
   logic [F-1:0]   x, y;
   logic [SW-1:0]  reduce_sum, add_sum, sub_raw, sub_sum;
   logic [SW-1:0]  s1_next_sum;
   logic           s1_next_err;

   logic           s1_v;
   logic [SW-1:0]  s1_sum;
   logic [TAG_W-1:0] s1_tag;
   logic           s1_err;
   logic           s1_adv;

   logic [DW-1:0]  d1, d2, d3, res;
   logic           unused_res_hi;

   assign op = op_e'(in_op);

   assign a0 = in_a[0*W +: W];
   assign a1 = in_a[1*W +: W];
   assign a2 = in_a[2*W +: W];
   assign a3 = in_a[3*W +: W];
   assign a4 = in_a[4*W +: W];
   assign a5 = in_a[5*W +: W];
   assign x  = in_a[F-1:0];
   assign y  = in_a[2*F-1:F];

   // 2^(3W) == 2^W + 1 (mod p), so the upper three words fold into the low half
   assign reduce_sum = {2'b00, a2, a1, a0}
                     + {{(W+2){1'b0}}, a3, a3}
                     + {2'b00, a4, a4, {W{1'b0}}}
                     + {2'b00, a5, a5, a5};

   assign add_sum = {2'b00, x} + {2'b00, y};

   // Adding p before subtracting avoids a borrow for in-range y.
   // An out-of-range y can still wrap; adding p again keeps S small enough for stage 2.
   assign sub_raw = {2'b00, x} + P_S - {2'b00, y};
   assign sub_sum = sub_raw[SW-1] ? (sub_raw + P_S) : sub_raw;

   // Stage 1 operation select: unreduced sum and the reserved-op flag
   always_comb begin
      s1_next_sum = '0;
      s1_next_err = 1'b0;
      case (op)
         OP_REDUCE: s1_next_sum = reduce_sum;
         OP_ADD:    s1_next_sum = add_sum;
         OP_SUB:    s1_next_sum = sub_sum;
         default:   s1_next_err = 1'b1;
      endcase
   end

   // Stage 2 empties or drains this cycle; stage 1 can refill as it moves on
   assign s1_adv   = !out_valid | out_ready;
   assign in_ready = !s1_v | s1_adv;

   // Stage 1 register: capture the sum, tag and error on accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v   <= 1'b0;
         s1_sum <= '0;
         s1_tag <= '0;
         s1_err <= 1'b0;
      end else if (in_ready) begin
         s1_v <= in_valid;
         if (in_valid) begin
            s1_sum <= s1_next_sum;
            s1_tag <= in_tag;
            s1_err <= s1_next_err;
         end
      end
   end

   // Candidates S-p, S-2p, S-3p; the top bit of each difference is its borrow
   assign d1 = {1'b0, s1_sum} - P1;
   assign d2 = {1'b0, s1_sum} - P2;
   assign d3 = {1'b0, s1_sum} - P3;

   // Pick the smallest non-negative candidate; the fold can exceed 3p, so all three are needed
   always_comb begin
      res = {1'b0, s1_sum};
      if (!d3[DW-1])
         res = d3;
      else if (!d2[DW-1])
         res = d2;
      else if (!d1[DW-1])
         res = d1;
   end

   // The selected value is below p, so its bits above F are always zero
   assign unused_res_hi = ^res[DW-1:F];

   // Stage 2 output register: load when the downstream slot frees, hold while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_tag   <= '0;
         out_err   <= 1'b0;
      end else if (s1_adv) begin
         out_valid <= s1_v;
         if (s1_v) begin
            out_data <= res[F-1:0];
            out_tag  <= s1_tag;
            out_err  <= s1_err;
         end
      end
   end

endmodule
